// File: rtl/pcbt_pkg.sv
// pcbt_pkg: shared binary32 constants, field layout, group-state encoding
// and a leading-zero counter for the adder's normalisation step.
package pcbt_pkg;

  localparam int          EXP_W    = 8;
  localparam int          MAN_W    = 23;
  localparam int          BIAS     = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic {
    GRP_IDLE = 1'b0,
    GRP_OPEN = 1'b1
  } grp_state_t;

  // Leading zeros of a 27-bit aligned mantissa (hidden bit at [26]); 27 for zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_add.sv
// fp32_add: combinational binary32 adder, round-to-nearest-even.
// Ports:
//   a, b : binary32 operands
//   sum  : binary32 result
// Build option PCBT_SUBNORMAL_EN: when defined, subnormal operands and results
// are exact; when undefined, subnormal operands read as signed zero and
// subnormal results flush to signed zero.
module fp32_add
  import pcbt_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  fp32_t              fa, fb, op_l, op_s;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic               swap, eff_sub, round_up, flush;
  logic [7:0]         e_l, e_s, d, dc, exp_field;
  logic [26:0]        m_l, m_s, m_al, n, n_sh;
  logic [53:0]        sh_tmp;
  logic [27:0]        raw;
  logic [4:0]         lz, sh;
  logic signed [10:0] e_n, lz_s;
  logic [30:0]        rounded;

  always_comb begin
    fa     = a;
    fb     = b;
    a_nan  = (fa.exp == 8'hFF) && (fa.man != '0);
    b_nan  = (fb.exp == 8'hFF) && (fb.man != '0);
    a_inf  = (fa.exp == 8'hFF) && (fa.man == '0);
    b_inf  = (fb.exp == 8'hFF) && (fb.man == '0);
`ifdef PCBT_SUBNORMAL_EN
    a_zero = (fa.exp == '0) && (fa.man == '0);
    b_zero = (fb.exp == '0) && (fb.man == '0);
`else
    a_zero = (fa.exp == '0);
    b_zero = (fb.exp == '0);
`endif

    // Larger magnitude becomes op_l; its sign is the result sign.
    swap = {fb.exp, fb.man} > {fa.exp, fa.man};
    op_l = swap ? fb : fa;
    op_s = swap ? fa : fb;
    e_l  = (op_l.exp == '0) ? 8'd1 : op_l.exp;
    e_s  = (op_s.exp == '0) ? 8'd1 : op_s.exp;
    m_l  = {op_l.exp != '0, op_l.man, 3'b000};
    m_s  = {op_s.exp != '0, op_s.man, 3'b000};

    // Align with guard/round bits plus a sticky bit collecting everything shifted out.
    d      = e_l - e_s;
    dc     = (d > 8'd27) ? 8'd27 : d;
    sh_tmp = {m_s, 27'b0} >> dc;
    m_al   = sh_tmp[53:27] | {26'b0, |sh_tmp[26:0]};

    eff_sub = op_l.sign ^ op_s.sign;
    raw     = eff_sub ? ({1'b0, m_l} - {1'b0, m_al}) : ({1'b0, m_l} + {1'b0, m_al});

    e_n = signed'({3'b000, e_l});
    if (raw[27]) begin
      n   = raw[27:1] | {26'b0, raw[0]};
      e_n = e_n + 11'sd1;
    end else begin
      n = raw[26:0];
    end

    lz   = lzc27(n);
    lz_s = signed'({6'b0, lz});
`ifdef PCBT_SUBNORMAL_EN
    // Stop normalising at the minimum exponent; what remains is a subnormal.
    if (lz_s < e_n - 11'sd1) sh = lz;
    else                     sh = 5'(e_n - 11'sd1);
    n_sh      = n << sh;
    e_n       = e_n - signed'({6'b0, sh});
    exp_field = n_sh[26] ? e_n[7:0] : 8'd0;
    flush     = 1'b0;
`else
    sh        = lz;
    n_sh      = n << sh;
    e_n       = e_n - lz_s;
    exp_field = e_n[7:0];
    flush     = (e_n <= 11'sd0) || !n_sh[26];
`endif

    // Adding into {exp, frac} lets a mantissa carry bump the exponent (and reach Inf).
    round_up = n_sh[2] & (n_sh[1] | n_sh[0] | n_sh[3]);
    rounded  = {exp_field, n_sh[25:3]} + 31'(round_up);

    if (a_nan || b_nan)           sum = QNAN;
    else if (a_inf && b_inf)      sum = (fa.sign != fb.sign) ? QNAN : a;
    else if (a_inf)               sum = a;
    else if (b_inf)               sum = b;
    else if (a_zero && b_zero)    sum = {fa.sign & fb.sign, 31'b0};
    else if (a_zero)              sum = b;
    else if (b_zero)              sum = a;
    else if (raw == '0)           sum = 32'h0000_0000;
    else if (e_n >= 11'sd255)     sum = {op_l.sign, 8'hFF, 23'b0};
    else if (flush)               sum = {op_l.sign, 31'b0};
    else                          sum = {op_l.sign, rounded};
  end

endmodule

// File: rtl/pcbt_wrapper.sv
// pcbt_wrapper: streaming binary32 group accumulator. Sums every accepted
// sample of a group and pulses valid_out with the total one cycle after the
// closing sample (end_of_group, or the max_inputs-th sample).
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   valid_in      : ip carries a sample
//   end_of_group  : accepted sample is the last of its group
//   ip            : binary32 sample
//   ready         : sample accepted this cycle when valid_in is high
//   valid_out     : one-cycle pulse, result holds the group sum
//   result        : binary32 group sum, held between pulses
// Build option PCBT_SUBNORMAL_EN selects exact subnormal handling in fp32_add.
//
// state    | meaning
// GRP_IDLE | no group open; next accepted sample starts a group
// GRP_OPEN | group in progress; acc holds the partial sum
module pcbt_wrapper
  import pcbt_pkg::*;
#(
  parameter int width      = 32,
  parameter int max_inputs = 32768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             end_of_group,
  input  logic [width-1:0] ip,
  output logic             ready,
  output logic             valid_out,
  output logic [width-1:0] result
);

  localparam int               CNT_W    = $clog2(max_inputs + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(max_inputs - 1);

  generate
    if (width != 32) begin : g_width_check
      $error("pcbt_wrapper: only width = 32 (binary32) is supported");
    end
  endgenerate

  grp_state_t       state;
  logic [width-1:0] acc, add_a, add_sum;
  logic [CNT_W-1:0] cnt;
  logic             accept, close_grp;

  // A group's first sample goes through the adder against -0.0, which returns
  // the sample unchanged (including -0.0) while applying the same operand
  // rules as every later sample.
  assign add_a = (state == GRP_OPEN) ? acc : NEG_ZERO;

  fp32_add u_add (
    .a   (add_a),
    .b   (ip),
    .sum (add_sum)
  );

  assign accept    = valid_in && ready;
  assign close_grp = end_of_group || (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GRP_IDLE;
      ready     <= 1'b0;
      valid_out <= 1'b0;
      result    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      ready     <= 1'b1;
      valid_out <= 1'b0;
      if (accept) begin
        if (close_grp) begin
          result    <= add_sum;
          valid_out <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          state     <= GRP_IDLE;
        end else begin
          acc   <= add_sum;
          cnt   <= cnt + 1'b1;
          state <= GRP_OPEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcbt_wrapper.sv
// tb_pcbt_wrapper: directed bench for pcbt_wrapper with a real-arithmetic
// reference model and per-cycle output comparison.
module tb_pcbt_wrapper;

  localparam int          MAXIN = 1024;
  localparam logic [31:0] QN    = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        end_of_group = 1'b0;
  logic [31:0] ip = '0;
  logic        ready, valid_out;
  logic [31:0] result;

  pcbt_wrapper #(.width(32), .max_inputs(MAXIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .end_of_group (end_of_group),
    .ip           (ip),
    .ready        (ready),
    .valid_out    (valid_out),
    .result       (result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          kind;     // 0: model only, 1: literal, 2: tolerance vs real sum
    logic [31:0] val;
    real         ref_sum;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] grp[$];

  // ---------------- reference arithmetic ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real m;
    int  e;
    e = int'(x[30:23]);
    if (e == 0) return 0.0;
    m = real'(int'({1'b1, x[22:0]})) * pow2(e - 150);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic s;
    real  a, m, fr;
    int   e, q;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= pow2(e + 1)) e++;
    while (a < pow2(e)) e--;
    m  = a / pow2(e - 23);
    q  = $rtoi(m);
    fr = m - real'(q);
    if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
    if (q == (1 << 24)) begin
      q = q / 2;
      e++;
    end
    if (e + 127 >= 255) return {s, 8'hFF, 23'h0};
    if (e + 127 <= 0)   return {s, 31'h0};
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    logic xn, yn, xi, yi, xz, yz;
    real  s;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    if (xn || yn)   return QN;
    if (xi && yi)   return (x[31] != y[31]) ? QN : x;
    if (xi)         return x;
    if (yi)         return y;
    if (xz && yz)   return {x[31] & y[31], 31'h0};
    if (xz)         return y;
    if (yz)         return x;
    s = f2r(x) + f2r(y);
    if (s == 0.0)   return 32'h0;
    return r2f(s);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] x);
    return (x[30:23] == 8'h00) ? {x[31], 31'h0} : x;
  endfunction

  // ---------------- behavioural model ----------------
  logic        m_ready = 1'b0, m_pulse = 1'b0, m_open = 1'b0, started = 1'b0;
  logic [31:0] m_acc = '0, m_res = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    started = 1'b1;
    m_pulse = 1'b0;
    if (rst) begin
      m_ready = 1'b0;
      m_open  = 1'b0;
      m_cnt   = 0;
      m_acc   = '0;
      m_res   = '0;
    end else begin
      if (valid_in && m_ready) begin
        m_acc = m_open ? m_add(m_acc, ip) : m_load(ip);
        m_cnt++;
        if (end_of_group || m_cnt == MAXIN) begin
          m_res   = m_acc;
          m_pulse = 1'b1;
          m_open  = 1'b0;
          m_cnt   = 0;
        end else begin
          m_open = 1'b1;
        end
      end
      m_ready = 1'b1;
    end
  end

  // ---------------- comparison ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    real  r, aerr, rel;
    if (started) begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("valid_out", 32'(valid_out), 32'(m_pulse));
      chk("result", result, m_res);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse at %0t: got result %h want no pulse", $time, result);
        end else begin
          e = exp_q.pop_front();
          if (e.kind == 1) begin
            chk("literal_dut", result, e.val);
            chk("literal_model", m_res, e.val);
          end else if (e.kind == 2) begin
            r    = f2r(result);
            aerr = r - e.ref_sum;
            if (aerr < 0.0) aerr = -aerr;
            rel  = (e.ref_sum != 0.0) ? aerr / ((e.ref_sum < 0.0) ? -e.ref_sum : e.ref_sum) : aerr;
            n_cmp++;
            if (!(rel <= 1e-6 || aerr <= 1e-6)) begin
              n_bad++;
              $display("FAIL tolerance: got %g want %g (rel err %g)", r, e.ref_sum, rel);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in     = 1'b0;
      end_of_group = 1'b0;
      ip           = '0;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic eog);
    @(negedge clk);
    valid_in     = 1'b1;
    end_of_group = eog;
    ip           = d;
  endtask

  task automatic run_group(input logic [31:0] expv);
    exp_t e;
    e.kind = 1; e.val = expv; e.ref_sum = 0.0;
    exp_q.push_back(e);
    for (int i = 0; i < grp.size(); i++) send(grp[i], (i == grp.size() - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    real  rsum;
    int   v;

    idle(5);
    rst = 1'b0;
    idle(1);

    grp = '{32'h3F80_0000};                             run_group(32'h3F80_0000);
    idle(2);
    grp = '{32'hBF80_0000, 32'hC000_0000, 32'hC040_0000}; run_group(32'hC0C0_0000);
    idle(2);
    grp = '{32'h40A0_0000};                             run_group(32'h40A0_0000);
    grp = '{32'h4000_0000, 32'h4000_0000};              run_group(32'h4080_0000);
    idle(2);
    grp = '{32'h4040_0000, 32'hC040_0000};              run_group(32'h0000_0000);
    grp = '{32'h7F80_0000, 32'hFF80_0000};              run_group(QN);
    grp = '{32'h8000_0000};                             run_group(32'h8000_0000);
    grp = '{32'h8000_0000, 32'h8000_0000};              run_group(32'h8000_0000);
    grp = '{32'h7F80_0000, 32'h3F80_0000};              run_group(32'h7F80_0000);
    grp = '{32'h3F80_0000, 32'h7F80_0001};              run_group(QN);
    grp = '{32'h7F7F_FFFF, 32'h7F7F_FFFF};              run_group(32'h7F80_0000);
    grp = '{32'hFF7F_FFFF, 32'hFF7F_FFFF};              run_group(32'hFF80_0000);
    grp = '{32'h3F80_0000, 32'h3380_0000};              run_group(32'h3F80_0000);
    grp = '{32'h3F80_0001, 32'h3380_0000};              run_group(32'h3F80_0002);
    grp = '{32'h3F80_0000, 32'hB380_0000};              run_group(32'h3F7F_FFFF);
    grp = '{32'h0000_0001, 32'h3F80_0000};              run_group(32'h3F80_0000);
    grp = '{32'h8040_0000};                             run_group(32'h8000_0000);
    grp = '{32'h0080_0001, 32'h8080_0000};              run_group(32'h0000_0000);
    idle(3);

    // 1000 random non-positive integers (multiples of 8) with an idle gap
    // carrying a stray end_of_group that must be ignored.
    rsum = 0.0;
    e.kind = 2; e.val = '0; e.ref_sum = 0.0;
    for (int i = 0; i < 1000; i++) begin
      v    = -8 * int'($urandom_range(0, 12500));
      rsum = rsum + real'(v);
      if (i == 500) begin
        @(negedge clk);
        valid_in = 1'b0; end_of_group = 1'b1; ip = 32'h4000_0000;
        idle(3);
      end
      if (i == 999) begin
        e.ref_sum = rsum;
        exp_q.push_back(e);
      end
      send(r2f(real'(v)), (i == 999));
    end
    idle(2);

    // A group closed by the sample count alone, then an immediate new group.
    e.kind = 1; e.val = 32'h4480_0000; e.ref_sum = 0.0;
    exp_q.push_back(e);
    for (int i = 0; i < MAXIN; i++) send(32'h3F80_0000, 1'b0);
    grp = '{32'h4000_0000};                             run_group(32'h4000_0000);
    idle(2);

    // Reset in the middle of an open group.
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b0);
    @(negedge clk);
    valid_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    grp = '{32'h40E0_0000};                             run_group(32'h40E0_0000);
    idle(5);

    chk("pending_pulses", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
